// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory/bus port among four requesters.
// A grant is held until done, request drop, or a MAX_HOLD-cycle timeout, then priority rotates.
module mem_port_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic             r_timeout;

  logic [1:0] w_start;
  logic [1:0] w_pick;
  logic       w_found;
  logic       w_hold_max;
  logic       w_owner_req;
  logic       w_release;
  logic       w_timeout_only;

  // Scan starts one past the last owner, so the current owner's own request is seen last.
  always_comb begin
    logic [1:0] idx;
    w_start = r_last + 2'd1;
    w_found = 1'b0;
    w_pick  = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = w_start + 2'(k);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  assign w_hold_max     = (r_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_owner_req    = req[r_last];
  assign w_release      = done | ~w_owner_req | w_hold_max;
  assign w_timeout_only = w_hold_max & ~done & w_owner_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 2'd3;
      r_cnt     <= '0;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= 4'b0001 << w_pick;
            r_sel   <= w_pick;
            r_last  <= w_pick;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_timeout <= w_timeout_only;
            if (w_found) begin
              r_gnt  <= 4'b0001 << w_pick;
              r_sel  <= w_pick;
              r_last <= w_pick;
              r_cnt  <= '0;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= 4'b0000;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: each driven cycle pushes its expected outputs,
// which are popped and compared just after the following rising edge.
module tb_mem_port_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  mem_port_arbiter #(
    .MAX_HOLD(16),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string tag, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic [1:0] es, input logic eb, input logic et);
    exp_t e;
    exp_t x;
    req  = r;
    done = d;
    e.gnt = eg; e.sel = es; e.busy = eb; e.to = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    $display("[TB] %-8s req=%b done=%b gnt=%b sel=%0d busy=%b timeout=%b",
             tag, r, d, gnt, sel, busy, timeout);
    check({tag, ".gnt"}, 32'(gnt), 32'(x.gnt));
    check({tag, ".sel"}, 32'(sel), 32'(x.sel));
    check({tag, ".busy"}, 32'(busy), 32'(x.busy));
    check({tag, ".to"}, 32'(timeout), 32'(x.to));
    check({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.to", 32'(timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req     = 4'b0000;
    done    = 1'b0;

    do_reset();

    // Single requester, done with request dropped, then done while idle.
    step("single", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("done",   4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("idledn", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Full contention rotates 0,1,2,3,0 with no idle gap between owners.
    do_reset();
    step("rr0", 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr1", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr2", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr3", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr4", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rridle", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold timeout: 16 cycles of grant, one-cycle pulse, re-grant of the sole requester.
    step("hold", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++)
      step("hold", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("tmo",  4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
    step("tmo+1", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("tmoend", 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Owner 1 drops its request while requester 3 waits.
    step("own1", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("drop1", 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("drpidl", 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

    // done coincident with the last hold cycle is a normal release (no timeout).
    step("dnmax", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++)
      step("dnmax", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("dnrel", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("dnrel+1", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("dnidle", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 1.
    do_reset();
    step("arst", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst.gnt", 32'(gnt), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.sel", 32'(sel), 32'd0);
    req = 4'b1010;
    @(negedge clk);
    reset = 1'b0;
    step("post", 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("post2", 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("post3", 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory/bus port among 4 requesters in the MIPS datapath (e.g. IF fetch, MEM load/store, debug/UART loader, spare).
- Drives the 2-bit select of the shared 4:1 port mux and a one-hot grant vector.
- Holds a grant until the owner signals done, drops its request, or a hold-timeout expires, then rotates priority.

Parameters:
- MAX_HOLD, 16, maximum cycles a single grant may be held before forced release; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants the port.
- done  input  1  current owner finished its transfer this cycle; ignored when no grant is active.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  registered mux select = index of the granted requester; holds its last value when idle.
- busy  output  1  registered; 1 while any grant is active.
- timeout  output  1  registered one-cycle pulse on a forced release caused by MAX_HOLD.

Behaviour:
- Reset (async, active-high): gnt=0, sel=0, busy=0, timeout=0, hold counter=0, last-owner pointer=3 (so requester 0 has first priority), FSM=IDLE.
- All outputs are registered; no combinational path from req/done to outputs.
- Round-robin pick: scan from (last+1) mod 4 upward with wrap and take the first i where req[i]=1. `last` updates to the winner on every grant.
- FSM IDLE:
  - If req==0, stay; gnt=0, busy=0.
  - Else grant the pick. gnt, sel and busy update on the next edge, giving a 1-cycle latency from req to gnt.
  - The hold counter clears to 0.
- FSM GRANT, evaluated every cycle:
  - Release conditions:
    - (a) done=1;
    - (b) req[owner]=0;
    - (c) counter==MAX_HOLD-1.
  - If there is no release, the counter increments and gnt/sel stay stable.
  - On release, re-arbitrate in the same cycle. Priority starts at owner+1, and the owner's own request is considered last.
    - If any req (including the owner's) is set, move directly to GRANT of the pick on the next edge with the counter cleared. There is no dead cycle between owners.
    - If no req is set, go to IDLE: gnt=0, busy=0, sel unchanged.
  - timeout=1 for exactly one cycle, coincident with the new gnt or idle state, only when release was caused solely by (c).
  - If done or req-drop coincides with counter==MAX_HOLD-1, it is a normal release and timeout=0.
- Ownership rules:
  - sel always equals the index of the set gnt bit while busy=1.
  - gnt never has more than one bit set.
- Starvation bound: any requester holding req high is granted within 3 × MAX_HOLD + 3 cycles.
- Reset mid-grant: gnt drops immediately (async); after reset deasserts, arbitration restarts from requester 0 priority.

Test Plan:
- Reset then req=4'b0001 → gnt=4'b0001, sel=0, busy=1 one cycle later; done pulse → next cycle gnt=0, busy=0, sel stays 0.
- req=4'b1111 held, done pulsed once per grant → grant order 0,1,2,3,0; each handover has zero idle cycles; sel tracks 0,1,2,3,0.
- MAX_HOLD=16, req=4'b0100 held, no done → gnt=4'b0100 for exactly 16 cycles, then timeout=1 for one cycle. gnt=4'b0100 is re-granted because it is the only requester, and the counter restarts.
- Owner 1 active, req[1] drops while req[3]=1 → next cycle gnt=4'b1000, sel=3, timeout=0.
- done asserted on the same cycle the counter reaches MAX_HOLD-1 → release with timeout=0; done asserted while idle → no state change.
- Async reset asserted mid-grant (gnt=4'b0010) → gnt=0, busy=0, sel=0 without waiting for a clock edge; after release with req=4'b1010, first grant goes to requester 1 (pointer restarted at 3 → first pick 0, then 1).
